mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock and one reset: clk rising-edge; rst_n asynchronous, active-low; no other clock or reset.
REQ-002 Ports SHALL be exactly:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  core memory request
- req_ready  out  1  controller idle, request accepted when both high
- req_op  in  4  0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 lwl, 6 lwr, 8 sb, 9 sh, 10 sw, 11 swl, 12 swr; others illegal
- req_addr  in  32  byte effective address
- req_wdata  in  32  store source register value
- req_rt  in  32  old rt value for lwl/lwr merge
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  load result (0 for stores)
- resp_err  out  1  alignment error (see Configuration)
- Address  out  32  word-aligned memory address
- MemRead / MemWrite  out  1 each  memory request strobes
- Write_data  out  32  memory store data
- Write_strb  out  4  byte enables
- Mem_Req_Ready  in  1  memory accepts request
- Read_data  in  32  memory read word
- Read_data_Valid  in  1  read word valid
- Read_data_Ready  out  1  controller accepts read word
- ext_ctrl  out  13  extender control code (define.v encoding)
- ext_ea  out  2  latched addr[1:0]
- ext_reg  out  32  wdata for stores, rt for loads
- ext_mem  out  32  driven from Read_data
- ext_data  in  32  extender result
- ext_strb  in  4  extender byte strobe

Function
REQ-003 FSM states SHALL be IDLE, REQ, RESP, DONE; req_ready=1 only in IDLE.
REQ-004 On req_valid&&req_ready, op/addr/wdata/rt SHALL be latched; next state REQ (legal, aligned), else DONE.
REQ-005 REQ: MemRead=1 for loads or MemWrite=1 for stores, Address={addr[31:2],2'b00}, Write_data=ext_data, Write_strb=ext_strb; all held stable until Mem_Req_Ready sampled high.
REQ-006 REQ with Mem_Req_Ready=1: store -> DONE, load -> RESP; strobes drop the following cycle.
REQ-007 RESP: Read_data_Ready=1; on Read_data_Valid, resp_data <= ext_data, state -> DONE.
REQ-008 Read_data_Valid outside RESP SHALL be ignored (Read_data_Ready=0).
REQ-009 DONE: resp_valid=1 for exactly one cycle, then IDLE; resp_data held until next completion.
REQ-010 Minimum latency accept->resp_valid: store 2 cycles, load 3 cycles, illegal/error 1 cycle.
REQ-011 Illegal op: no memory strobe, resp_data=0, resp_err=0.
REQ-012 ext_ctrl/ext_ea/ext_reg SHALL derive only from latched fields; changes on req_* during a transaction SHALL have no effect.
REQ-013 Stores SHALL set resp_data=0.

Reset
REQ-014 rst_n low SHALL force IDLE immediately; req_ready=1 after release; resp_valid, resp_err, MemRead, MemWrite, Read_data_Ready=0; resp_data, Address, latched fields=0.
REQ-015 Reset mid-transaction SHALL abandon it with no resp_valid; a late Read_data_Valid SHALL be ignored.

Configuration
REQ-016 Macro MEM_ALIGN_CHECK_EN defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, SHALL skip memory, go to DONE with resp_err=1, resp_data=0.
REQ-017 Macro undefined: no check, access proceeds word-aligned, resp_err tied 0.

Verification
REQ-018 sw addr 0x104, wdata 0xDEADBEEF, Mem_Req_Ready high after 2 cycles -> MemWrite held 3 cycles, Address 0x104, Write_strb 1111, resp_valid 1 cycle later.
REQ-019 lb addr 0x203, Read_data 0x80FF_FFFF returned after 4 cycles -> Address 0x200, resp_data 0xFFFFFF80.
REQ-020 lwl addr 0x11, rt 0x11223344, Read_data 0xAABBCCDD -> resp_data 0xCCDD3344.
REQ-021 With MEM_ALIGN_CHECK_EN: lw addr 0x2 -> no MemRead, resp_valid next cycle, resp_err 1; without macro: MemRead, Address 0x0, resp_err 0.
REQ-022 rst_n pulsed low while in RESP, then Read_data_Valid -> no resp_valid, req_ready=1, next lw completes normally.
REQ-023 req_op 7 -> resp_valid after 1 cycle, resp_data 0, no memory strobe; req_valid held during busy -> second request accepted only after return to IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: latches one request, drives a single memory transaction and returns the extender's result.
// Optional MEM_ALIGN_CHECK_EN: misaligned lh/lhu/sh/lw/sw complete at once with resp_err=1 and no memory access.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] Address,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Write_data,
    output logic [3:0]  Write_strb,
    input  logic        Mem_Req_Ready,
    input  logic [31:0] Read_data,
    input  logic        Read_data_Valid,
    output logic        Read_data_Ready,
    output logic [12:0] ext_ctrl,
    output logic [1:0]  ext_ea,
    output logic [31:0] ext_reg,
    output logic [31:0] ext_mem,
    input  logic [31:0] ext_data,
    input  logic [3:0]  ext_strb
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rt_q, rt_d;
    logic        req_ready_q, req_ready_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        rd_ready_q, rd_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        req_legal;
    logic        req_misaligned;
    logic        op_legal_q;

    function automatic logic op_is_legal(input logic [3:0] op);
        return !((op == 4'd7) || (op > 4'd12));
    endfunction

    assign req_legal  = op_is_legal(req_op);
    assign op_legal_q = op_is_legal(op_q);

`ifdef MEM_ALIGN_CHECK_EN
    assign req_misaligned = (((req_op == 4'd1) || (req_op == 4'd4) || (req_op == 4'd9)) && req_addr[0])
                         || (((req_op == 4'd2) || (req_op == 4'd10)) && (req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rt_d         = rt_q;
        req_ready_d  = req_ready_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        rd_ready_d   = rd_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rt_d        = req_rt;
                    req_ready_d = 1'b0;
                    if (req_legal && !req_misaligned) begin
                        state_d     = REQ;
                        mem_read_d  = !req_op[3];
                        mem_write_d = req_op[3];
                    end else begin
                        // Illegal or misaligned: complete immediately without touching memory
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = req_misaligned;
                        resp_data_d  = 32'h0;
                    end
                end
            end
            REQ: begin
                if (Mem_Req_Ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (op_q[3]) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_data_d  = 32'h0;
                    end else begin
                        state_d    = RESP;
                        rd_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (Read_data_Valid) begin
                    state_d      = DONE;
                    rd_ready_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = ext_data;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                rd_ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= 4'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            rt_q         <= 32'h0;
            req_ready_q  <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            rd_ready_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rt_q         <= rt_d;
            req_ready_q  <= req_ready_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            rd_ready_q   <= rd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Extender control is one-hot on the latched opcode value; illegal opcodes select nothing
    for (genvar gi = 0; gi < 13; gi++) begin : g_ext_ctrl
        assign ext_ctrl[gi] = op_legal_q && (op_q == 4'(gi));
    end

    assign ext_ea          = addr_q[1:0];
    assign ext_reg         = op_q[3] ? wdata_q : rt_q;
    assign ext_mem         = Read_data;
    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_err        = resp_err_q;
    assign Address         = {addr_q[31:2], 2'b00};
    assign MemRead         = mem_read_q;
    assign MemWrite        = mem_write_q;
    assign Write_data      = mem_write_q ? ext_data : 32'h0;
    assign Write_strb      = mem_write_q ? ext_strb : 4'h0;
    assign Read_data_Ready = rd_ready_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural extender + memory, directed scenarios and randomized transactions vs. a reference model.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_rt;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] Address;
    logic        MemRead, MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    logic [12:0] ext_ctrl;
    logic [1:0]  ext_ea;
    logic [31:0] ext_reg, ext_mem, ext_data;
    logic [3:0]  ext_strb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
        .Write_data(Write_data), .Write_strb(Write_strb),
        .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
        .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
        .ext_ctrl(ext_ctrl), .ext_ea(ext_ea), .ext_reg(ext_reg), .ext_mem(ext_mem),
        .ext_data(ext_data), .ext_strb(ext_strb)
    );

    // Reference semantics of every load/store in little-endian byte order
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] ea,
                                               input logic [31:0] rt, input logic [31:0] mem);
        logic [31:0] b, h;
        int sh;
        sh = 8 * int'(ea);
        b  = (mem >> sh) & 32'hFF;
        h  = ea[1] ? (mem >> 16) : (mem & 32'hFFFF);
        case (op)
            4'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            4'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            4'd2:    return mem;
            4'd3:    return b;
            4'd4:    return h;
            4'd5:    return (mem << (24 - sh)) | (rt & (32'hFFFF_FFFF >> (sh + 8)));
            4'd6:    return (mem >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_sdata(input logic [3:0] op, input logic [1:0] ea,
                                                input logic [31:0] w);
        int sh;
        sh = 8 * int'(ea);
        case (op)
            4'd8:    return {4{w[7:0]}};
            4'd9:    return {2{w[15:0]}};
            4'd10:   return w;
            4'd11:   return w >> (24 - sh);
            4'd12:   return w << sh;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] model_sstrb(input logic [3:0] op, input logic [1:0] ea);
        logic [3:0] f;
        f = 4'hF;
        case (op)
            4'd8:    return 4'b0001 << ea;
            4'd9:    return ea[1] ? 4'b1100 : 4'b0011;
            4'd10:   return 4'b1111;
            4'd11:   return f >> (2'd3 - ea);
            4'd12:   return f << ea;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd6) || ((op >= 4'd8) && (op <= 4'd12));
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        if ((op == 4'd1 || op == 4'd4 || op == 4'd9) && a[0]) return 1'b1;
        if ((op == 4'd2 || op == 4'd10) && a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Stand-in for the external extender unit (one-hot ext_ctrl, bit index = opcode)
    always_comb begin
        logic [3:0] dop;
        logic       found;
        dop      = 4'h0;
        found    = 1'b0;
        ext_data = 32'h0;
        ext_strb = 4'h0;
        for (int i = 0; i < 13; i++) begin
            if (ext_ctrl[i]) begin
                dop   = 4'(i);
                found = 1'b1;
            end
        end
        if (found) begin
            if (dop[3]) begin
                ext_data = model_sdata(dop, ext_ea, ext_reg);
                ext_strb = model_sstrb(dop, ext_ea);
            end else begin
                ext_data = model_load(dop, ext_ea, ext_reg, ext_mem);
            end
        end
    end

    typedef struct {
        int          lat;
        int          mem_cycles;
        logic        saw_rd;
        logic        saw_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        err;
        logic        busy_ready;
        logic        rv_after;
        logic        ready_after;
    } obs_t;

    // Drives one request, plays the memory side and records what the DUT did
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rt, input logic [31:0] rdata,
                           input int req_dly, input int rsp_dly, output obs_t o);
        int strobe_n, rdr_n, waited;
        o = '{lat: -1, mem_cycles: 0, saw_rd: 1'b0, saw_wr: 1'b0, addr: 32'h0, wdata: 32'h0,
              strb: 4'h0, data: 32'hX, err: 1'bX, busy_ready: 1'b0, rv_after: 1'bX, ready_after: 1'bX};
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt = rt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rt = $urandom;
        strobe_n = 0;
        rdr_n    = 0;
        for (int k = 0; k < 40; k++) begin
            Mem_Req_Ready   = 1'b0;
            Read_data_Valid = 1'b0;
            Read_data       = $urandom;
            if (req_ready) o.busy_ready = 1'b1;
            if (MemRead || MemWrite) begin
                o.saw_rd |= MemRead;
                o.saw_wr |= MemWrite;
                o.addr  = Address;
                o.wdata = Write_data;
                o.strb  = Write_strb;
                o.mem_cycles++;
                Mem_Req_Ready = (strobe_n == req_dly);
                strobe_n++;
            end
            if (Read_data_Ready) begin
                if (rdr_n == rsp_dly) begin
                    Read_data_Valid = 1'b1;
                    Read_data       = rdata;
                end
                rdr_n++;
            end else begin
                Read_data_Valid = 1'($urandom_range(0, 1));
            end
            if (resp_valid) begin
                o.lat  = k + 1;
                o.data = resp_data;
                o.err  = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        Mem_Req_Ready   = 1'b0;
        Read_data_Valid = 1'b0;
        @(posedge clk); #1;
        o.rv_after    = resp_valid;
        o.ready_after = req_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({req_ready, resp_valid, resp_err, MemRead, MemWrite, Read_data_Ready} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=100000",
                     {req_ready, resp_valid, resp_err, MemRead, MemWrite, Read_data_Ready});
        end
        n_tests++;
        if ({resp_data, Address, ext_reg, ext_ea} !== 98'h0) begin
            n_fail++;
            $display("FAIL reset_data got resp_data=%h Address=%h ext_reg=%h ext_ea=%b exp all 0",
                     resp_data, Address, ext_reg, ext_ea);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_sw_directed();
        obs_t o;
        run_txn(4'd10, 32'h104, 32'hDEAD_BEEF, 32'h0, 32'h0, 2, 0, o);
        $display("[TB] sw addr=00000104 lat=%0d mw_cycles=%0d", o.lat, o.mem_cycles);
        n_tests++;
        if (o.mem_cycles !== 3 || o.saw_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_memwrite_cycles got=%0d rd=%b exp=3 rd=0", o.mem_cycles, o.saw_rd);
        end
        n_tests++;
        if (o.addr !== 32'h104 || o.strb !== 4'hF || o.wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL sw_bus got addr=%h strb=%b wd=%h exp 00000104 1111 deadbeef", o.addr, o.strb, o.wdata);
        end
        n_tests++;
        if (o.lat !== 4 || o.data !== 32'h0 || o.err !== 1'b0 || o.rv_after !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_resp got lat=%0d data=%h err=%b rv_after=%b exp 4 0 0 0", o.lat, o.data, o.err, o.rv_after);
        end
    endtask

    task automatic test_load_directed();
        obs_t o;
        run_txn(4'd0, 32'h203, 32'h0, 32'h0, 32'h80FF_FFFF, 0, 4, o);
        $display("[TB] lb addr=00000203 lat=%0d data=%h", o.lat, o.data);
        n_tests++;
        if (o.addr !== 32'h200 || o.saw_rd !== 1'b1 || o.saw_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_bus got addr=%h rd=%b wr=%b exp 00000200 1 0", o.addr, o.saw_rd, o.saw_wr);
        end
        n_tests++;
        if (o.data !== 32'hFFFF_FF80 || o.lat !== 7) begin
            n_fail++;
            $display("FAIL lb_resp got data=%h lat=%0d exp ffffff80 7", o.data, o.lat);
        end
        run_txn(4'd5, 32'h11, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, o);
        $display("[TB] lwl addr=00000011 lat=%0d data=%h", o.lat, o.data);
        n_tests++;
        if (o.data !== 32'hCCDD_3344 || o.lat !== 3 || o.addr !== 32'h10) begin
            n_fail++;
            $display("FAIL lwl_resp got data=%h lat=%0d addr=%h exp ccdd3344 3 00000010", o.data, o.lat, o.addr);
        end
    endtask

    task automatic test_align();
        obs_t o;
        run_txn(4'd2, 32'h2, 32'h0, 32'h0, 32'h1234_5678, 0, 0, o);
        $display("[TB] lw addr=00000002 lat=%0d err=%b", o.lat, o.err);
`ifdef MEM_ALIGN_CHECK_EN
        n_tests++;
        if (o.saw_rd !== 1'b0 || o.lat !== 1 || o.err !== 1'b1 || o.data !== 32'h0) begin
            n_fail++;
            $display("FAIL align_err got rd=%b lat=%0d err=%b data=%h exp 0 1 1 0", o.saw_rd, o.lat, o.err, o.data);
        end
`else
        n_tests++;
        if (o.saw_rd !== 1'b1 || o.addr !== 32'h0 || o.err !== 1'b0 || o.data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL align_nochk got rd=%b addr=%h err=%b data=%h exp 1 0 0 12345678", o.saw_rd, o.addr, o.err, o.data);
        end
`endif
    endtask

    task automatic test_illegal_busy();
        obs_t o;
        int accepts, pulses, bad;
        run_txn(4'd7, 32'h40, 32'h5, 32'h6, 32'h0, 0, 0, o);
        $display("[TB] op7 lat=%0d data=%h", o.lat, o.data);
        n_tests++;
        if (o.lat !== 1 || o.data !== 32'h0 || o.err !== 1'b0 || o.mem_cycles !== 0) begin
            n_fail++;
            $display("FAIL illegal_resp got lat=%0d data=%h err=%b strobes=%0d exp 1 0 0 0", o.lat, o.data, o.err, o.mem_cycles);
        end
        accepts = 0; pulses = 0; bad = 0;
        req_valid = 1'b1; req_op = 4'd7;
        for (int c = 0; c < 6; c++) begin
            if (req_ready) accepts++;
            if (resp_valid) pulses++;
            if (resp_valid && (req_ready || resp_data !== 32'h0)) bad++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        n_tests++;
        if (accepts !== 3 || pulses !== 3 || bad !== 0) begin
            n_fail++;
            $display("FAIL illegal_held got accepts=%0d pulses=%0d bad=%0d exp 3 3 0", accepts, pulses, bad);
        end
        accepts = 0;
        req_valid = 1'b1; req_op = 4'd10; req_addr = 32'h40; req_wdata = 32'h1;
        for (int c = 0; c < 8; c++) begin
            if (req_ready) accepts++;
            Mem_Req_Ready = MemWrite;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int c = 0; c < 4 && !req_ready; c++) begin
            Mem_Req_Ready = MemWrite;
            @(posedge clk); #1;
        end
        Mem_Req_Ready = 1'b0;
        n_tests++;
        if (accepts !== 3 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL store_held got accepts=%0d ready=%b exp 3 1", accepts, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int stray;
        req_valid = 1'b1; req_op = 4'd2; req_addr = 32'h300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        Mem_Req_Ready = 1'b1;
        @(posedge clk); #1;
        Mem_Req_Ready = 1'b0;
        n_tests++;
        if (Read_data_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_resp got rdr=%b exp 1", Read_data_Ready);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, Read_data_Ready, MemRead, resp_valid} !== 4'b1000 || Address !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_async got ctrl=%b addr=%h exp 1000 0",
                     {req_ready, Read_data_Ready, MemRead, resp_valid}, Address);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        Read_data_Valid = 1'b1; Read_data = 32'hFACE_F00D;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (resp_valid || Read_data_Ready || !req_ready) stray++;
        end
        Read_data_Valid = 1'b0;
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL midrst_late_valid got stray=%0d exp 0", stray);
        end
        run_txn(4'd2, 32'h304, 32'h0, 32'h0, 32'h0BAD_CAFE, 1, 1, o);
        $display("[TB] lw after reset lat=%0d data=%h", o.lat, o.data);
        n_tests++;
        if (o.data !== 32'h0BAD_CAFE || o.lat !== 5 || o.addr !== 32'h304) begin
            n_fail++;
            $display("FAIL midrst_next_lw got data=%h lat=%0d addr=%h exp 0badcafe 5 00000304", o.data, o.lat, o.addr);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [3:0]  op;
        logic [31:0] addr, wd, rt, rd;
        int          rq, rs, exp_lat;
        logic        touch, st;
        logic [31:0] exp_data;
        for (int t = 0; t < 40; t++) begin
            op = 4'($urandom_range(0, 15));
            addr = $urandom; wd = $urandom; rt = $urandom; rd = $urandom;
            rq = $urandom_range(0, 3); rs = $urandom_range(0, 3);
            run_txn(op, addr, wd, rt, rd, rq, rs, o);
            touch = op_legal(op) && !op_misaligned(op, addr);
            st = op[3];
            exp_lat  = !touch ? 1 : (st ? 2 + rq : 3 + rq + rs);
            exp_data = (touch && !st) ? model_load(op, addr[1:0], rt, rd) : 32'h0;
            $display("[TB] txn %0d op=%0d addr=%h lat=%0d data=%h err=%b", t, op, addr, o.lat, o.data, o.err);
            n_tests++;
            if (o.lat !== exp_lat || o.mem_cycles !== (touch ? rq + 1 : 0)) begin
                n_fail++;
                $display("FAIL rnd_timing txn=%0d got lat=%0d strobes=%0d exp %0d %0d",
                         t, o.lat, o.mem_cycles, exp_lat, touch ? rq + 1 : 0);
            end
            n_tests++;
            if (o.saw_rd !== (touch && !st) || o.saw_wr !== (touch && st)
                || (touch && o.addr !== {addr[31:2], 2'b00})) begin
                n_fail++;
                $display("FAIL rnd_strobe txn=%0d got rd=%b wr=%b addr=%h", t, o.saw_rd, o.saw_wr, o.addr);
            end
            if (touch && st) begin
                n_tests++;
                if (o.wdata !== model_sdata(op, addr[1:0], wd) || o.strb !== model_sstrb(op, addr[1:0])) begin
                    n_fail++;
                    $display("FAIL rnd_store txn=%0d got wd=%h strb=%b exp %h %b", t, o.wdata, o.strb,
                             model_sdata(op, addr[1:0], wd), model_sstrb(op, addr[1:0]));
                end
            end
            n_tests++;
            if (o.data !== exp_data || o.err !== (op_legal(op) && op_misaligned(op, addr))) begin
                n_fail++;
                $display("FAIL rnd_resp txn=%0d got data=%h err=%b exp %h %b", t, o.data, o.err,
                         exp_data, op_legal(op) && op_misaligned(op, addr));
            end
            n_tests++;
            if (o.busy_ready !== 1'b0 || o.rv_after !== 1'b0 || o.ready_after !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_handshake txn=%0d got busy_ready=%b rv_after=%b ready_after=%b exp 0 0 1",
                         t, o.busy_ready, o.rv_after, o.ready_after);
            end
        end
    endtask

    initial begin
        req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0; req_rt = 32'h0;
        Mem_Req_Ready = 1'b0; Read_data = 32'h0; Read_data_Valid = 1'b0;
        test_reset();
        test_sw_directed();
        test_load_directed();
        test_align();
        test_illegal_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
